// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the RX/TX paths of the uart-wrapper.
// Keeps the receiver state encoding and bit-timing arithmetic in one place.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // Counter value at which the middle of the start bit is reached.
   function automatic int half_bit(input int clks);
      return clks / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous line that idles high.
// Resets to 1 so a freshly reset receiver never sees a false start edge.
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], d};
      end
   end

   assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver that writes each good byte straight into the RX FIFO.
// Bytes arriving while the FIFO is full are dropped and flagged as overruns.
module uart_rx_fifo_writer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   input  logic                  fifo_full,
   output logic                  fifo_write,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   output logic                  rx_busy,
   output logic                  frame_err,
   output logic                  overrun_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(half_bit(CLKS_PER_BIT));
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
         $error("uart_rx_fifo_writer: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   logic                  rx_s;
   rx_state_t             state_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [IDX_W-1:0]      bit_idx_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  fifo_write_reg;
   logic                  rx_busy_reg;
   logic                  frame_err_reg;
   logic                  overrun_err_reg;

   uart_sync2 u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         bit_idx_reg     <= '0;
         shift_reg       <= '0;
         wdata_reg       <= '0;
         fifo_write_reg  <= 1'b0;
         rx_busy_reg     <= 1'b0;
         frame_err_reg   <= 1'b0;
         overrun_err_reg <= 1'b0;
      end else begin
         fifo_write_reg  <= 1'b0;
         frame_err_reg   <= 1'b0;
         overrun_err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (!rx_s) begin
                  state_reg   <= START;
                  cnt_reg     <= '0;
                  rx_busy_reg <= 1'b1;
               end
            end

            START: begin
               if (cnt_reg == HALF_CNT) begin
                  // Line back high at mid-start means it was only a glitch.
                  if (rx_s) begin
                     state_reg   <= IDLE;
                     rx_busy_reg <= 1'b0;
                  end else begin
                     state_reg   <= DATA;
                     cnt_reg     <= '0;
                     bit_idx_reg <= '0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            DATA: begin
               if (cnt_reg == LAST_CNT) begin
                  cnt_reg   <= '0;
                  shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                  if (bit_idx_reg == LAST_IDX) begin
                     state_reg   <= STOP;
                     bit_idx_reg <= '0;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            STOP: begin
               if (cnt_reg == LAST_CNT) begin
                  cnt_reg <= '0;
                  if (rx_s) begin
                     // Return mid-stop-bit so a back-to-back start edge is caught.
                     state_reg   <= IDLE;
                     rx_busy_reg <= 1'b0;
                     if (fifo_full) begin
                        overrun_err_reg <= 1'b1;
                     end else begin
                        fifo_write_reg <= 1'b1;
                        wdata_reg      <= shift_reg;
                     end
                  end else begin
                     frame_err_reg <= 1'b1;
                     state_reg     <= WAIT_HIGH;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            WAIT_HIGH: begin
               if (rx_s) begin
                  state_reg   <= IDLE;
                  rx_busy_reg <= 1'b0;
               end
            end

            default: begin
               state_reg   <= IDLE;
               rx_busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_write  = fifo_write_reg;
   assign fifo_wdata  = wdata_reg;
   assign rx_busy     = rx_busy_reg;
   assign frame_err   = frame_err_reg;
   assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Scoreboard bench for uart_rx_fifo_writer: frames are serialised by tasks,
// expected FIFO/error events are queued and checked by an output monitor.
module tb_uart_rx_fifo_writer;

   localparam int CPB     = 16;
   localparam int DW      = 8;
   localparam int LATENCY = 2 + CPB / 2 + (DW + 1) * CPB + 1;

   localparam logic [2:0] EV_WR    = 3'b001;
   localparam logic [2:0] EV_FRAME = 3'b010;
   localparam logic [2:0] EV_OVR   = 3'b100;

   typedef struct {
      logic [2:0] ev;
      logic [7:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx = 1'b1;
   logic          fifo_full = 1'b0;
   logic          fifo_write;
   logic [DW-1:0] fifo_wdata;
   logic          rx_busy;
   logic          frame_err;
   logic          overrun_err;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            last_write_cyc = -1;
   int            fall_cyc;
   logic [7:0]    model_last = 8'h00;
   logic          prev_write = 1'b0;
   logic [2:0]    mon_act;
   exp_t          mon_e;
   exp_t          exp_q[$];

   uart_rx_fifo_writer #(
      .CLKS_PER_BIT (CPB),
      .DATA_WIDTH   (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .fifo_full   (fifo_full),
      .fifo_write  (fifo_write),
      .fifo_wdata  (fifo_wdata),
      .rx_busy     (rx_busy),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      if (n > 0) #1;
   endtask

   // Reference rule: bad stop -> frame error; good stop with FIFO full ->
   // overrun with the previous byte still presented; otherwise a write.
   task automatic push_frame(input logic [7:0] b, input logic stop, input logic full);
      if (!stop) begin
         exp_q.push_back('{ev: EV_FRAME, data: 8'h00});
      end else if (full) begin
         exp_q.push_back('{ev: EV_OVR, data: model_last});
      end else begin
         exp_q.push_back('{ev: EV_WR, data: b});
         model_last = b;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
   endtask

   // Output monitor: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      mon_act = {overrun_err, frame_err, fifo_write};
      if (fifo_write) check("write_not_back_to_back", {31'd0, prev_write}, 32'd0);
      prev_write = fifo_write;
      if (rst_n && mon_act != 3'b000) begin
         if (fifo_write) last_write_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=%b required=none", mon_act);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", {29'd0, mon_act}, {29'd0, mon_e.ev});
            if (mon_e.ev != EV_FRAME)
               check("event_data", {24'd0, fifo_wdata}, {24'd0, mon_e.data});
            $display("txn cyc=%0d ev=%b exp_ev=%b wdata=0x%02h exp_data=0x%02h",
                     cyc, mon_act, mon_e.ev, fifo_wdata, mon_e.data);
         end
      end
   end

   initial begin
      logic [7:0] b;
      logic       bad;
      logic       full;

      // Reset state
      rst_n = 1'b0;
      rx = 1'b1;
      fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_fifo_write", {31'd0, fifo_write}, 32'd0);
      check("rst_fifo_wdata", {24'd0, fifo_wdata}, 32'd0);
      check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
      check("rst_errors", {30'd0, frame_err, overrun_err}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(4);

      // Single frame 0xA5 with latency measurement
      fall_cyc = cyc;
      push_frame(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b1);
      tick(2);
      @(negedge clk);
      check("a5_latency", last_write_cyc - fall_cyc, LATENCY);
      check("a5_busy_idle", {31'd0, rx_busy}, 32'd0);
      check("a5_drained", exp_q.size(), 0);
      tick(1);

      // Back-to-back frames with no idle gap
      push_frame(8'h00, 1'b1, 1'b0);
      push_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      tick(4);
      @(negedge clk);
      check("b2b_drained", exp_q.size(), 0);
      tick(1);

      // Start glitch: 4 cycles low
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(1);
      @(negedge clk);
      check("glitch_busy_start", {31'd0, rx_busy}, 32'd1);
      tick(5);
      @(negedge clk);
      check("glitch_busy_before_sample", {31'd0, rx_busy}, 32'd1);
      tick(1);
      @(negedge clk);
      check("glitch_busy_after_sample", {31'd0, rx_busy}, 32'd0);
      tick(20);

      // Stop bit low followed by a held break
      push_frame(8'h96, 1'b0, 1'b0);
      send_frame(8'h96, 1'b0);
      tick(100);
      @(negedge clk);
      check("break_busy_held", {31'd0, rx_busy}, 32'd1);
      tick(1);
      rx = 1'b1;
      tick(1);
      @(negedge clk);
      check("break_busy_sync_lag", {31'd0, rx_busy}, 32'd1);
      tick(3);
      @(negedge clk);
      check("break_busy_released", {31'd0, rx_busy}, 32'd0);
      tick(1);
      push_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1);
      tick(4);

      // Overrun: FIFO full during the stop bit of 0x5A
      push_frame(8'h5A, 1'b1, 1'b1);
      fifo_full = 1'b1;
      send_frame(8'h5A, 1'b1);
      fifo_full = 1'b0;
      tick(4);
      @(negedge clk);
      check("overrun_wdata_held", {24'd0, fifo_wdata}, 32'h3C);
      check("overrun_drained", exp_q.size(), 0);
      tick(1);

      // Reset during bit 4 of a frame
      rx = 1'b0;
      tick(CPB + 4 * CPB + CPB / 2);
      rst_n = 1'b0;
      model_last = 8'h00;
      tick(2);
      @(negedge clk);
      check("midrst_fifo_write", {31'd0, fifo_write}, 32'd0);
      check("midrst_fifo_wdata", {24'd0, fifo_wdata}, 32'd0);
      check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
      check("midrst_errors", {30'd0, frame_err, overrun_err}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx = 1'b1;
      tick(40);
      @(negedge clk);
      check("midrst_no_events", exp_q.size(), 0);
      check("midrst_busy_idle", {31'd0, rx_busy}, 32'd0);
      tick(1);
      push_frame(8'h81, 1'b1, 1'b0);
      send_frame(8'h81, 1'b1);
      tick(4);

      // Randomised frames: random data, stop-bit errors, FIFO full and gaps
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom_range(0, 255));
         bad  = ($urandom_range(0, 5) == 0);
         full = ($urandom_range(0, 3) == 0);
         push_frame(b, !bad, full);
         fifo_full = full;
         send_frame(b, !bad);
         fifo_full = 1'b0;
         rx = 1'b1;
         if (bad) tick($urandom_range(4, 20));
         else tick($urandom_range(0, 12));
      end

      tick(30);
      @(negedge clk);
      check("final_drained", exp_q.size(), 0);
      check("final_busy_idle", {31'd0, rx_busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
